// File: rtl/microwave_pkg.sv
// Shared encodings, digit limits and helpers for the microwave cooking timer.
package microwave_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MIN_W   = 4;
  localparam int unsigned STENS_W = 3;
  localparam int unsigned SONES_W = 4;

  localparam int unsigned MAX_MIN   = 9;
  localparam int unsigned MAX_STENS = 5;
  localparam int unsigned MAX_SONES = 9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  // True when every digit of an operator load is a legal BCD code for its position.
  function automatic logic digits_valid(input logic [MIN_W-1:0]   m,
                                        input logic [STENS_W-1:0] t,
                                        input logic [SONES_W-1:0] o);
    return (m <= MIN_W'(MAX_MIN)) && (t <= STENS_W'(MAX_STENS)) && (o <= SONES_W'(MAX_SONES));
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Operator controls in, time/status display out.
interface microwave_timer_ctrl_if;
  import microwave_pkg::*;

  logic               load;
  logic [MIN_W-1:0]   min_in;
  logic [STENS_W-1:0] stens_in;
  logic [SONES_W-1:0] sones_in;
  logic               start;
  logic               stop;
  logic               door_closed;
  logic [MIN_W-1:0]   min_out;
  logic [STENS_W-1:0] stens_out;
  logic [SONES_W-1:0] sones_out;
  logic               mag_on;
  logic               done;
  logic [STATE_W-1:0] state_out;

  modport master (
    output load, min_in, stens_in, sones_in, start, stop, door_closed,
    input  min_out, stens_out, sones_out, mag_on, done, state_out
  );

  modport slave (
    input  load, min_in, stens_in, sones_in, start, stop, door_closed,
    output min_out, stens_out, sones_out, mag_on, done, state_out
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX and flags a borrow to the next digit.
module bcd_down_digit #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 9
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         dec_en,
  output logic [W-1:0] q,
  output logic         borrow
);

  assign borrow = dec_en && (q == '0);

  // Digit register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (dec_en) begin
      q <= (q == '0) ? W'(MAX) : q - W'(1);
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cooking-timer FSM: M:SS countdown, 1 s prescaler, magnetron enable and done hold-off.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 4,
  parameter int unsigned DONE_SECS     = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  microwave_timer_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam int unsigned DW = $clog2(DONE_SECS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_SECS - 1);

  state_e             state, state_n;
  logic [PW-1:0]      presc, presc_n;
  logic [DW-1:0]      dcnt, dcnt_n;
  logic               tick, dec, dig_load, dig_zero;
  logic               time_zero, time_one;
  logic [MIN_W-1:0]   min_q;
  logic [STENS_W-1:0] stens_q;
  logic [SONES_W-1:0] sones_q;
  logic               sones_borrow, stens_borrow, unused_min_borrow;

  assign tick      = (presc == TICK_LAST);
  assign time_zero = (min_q == '0) && (stens_q == '0) && (sones_q == '0);
  assign time_one  = (min_q == '0) && (stens_q == '0) && (sones_q == SONES_W'(1));

  // Next-state, prescaler and digit-control decode.
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    dcnt_n   = dcnt;
    dec      = 1'b0;
    dig_load = 1'b0;
    dig_zero = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.load) begin
          dig_load = digits_valid(bus.min_in, bus.stens_in, bus.sones_in);
        end else if (bus.start && bus.door_closed && !time_zero) begin
          state_n = ST_RUN;
          presc_n = '0;
        end else if (bus.stop) begin
          dig_load = 1'b1;
          dig_zero = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.stop || !bus.door_closed) begin
          state_n = ST_PAUSE;
        end else begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            dec = 1'b1;
            if (time_one) begin
              state_n = ST_DONE;
              dcnt_n  = '0;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          state_n  = ST_IDLE;
          dig_load = 1'b1;
          dig_zero = 1'b1;
        end else if (bus.start && bus.door_closed) begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.stop || !bus.door_closed) begin
          state_n = ST_IDLE;
        end else begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (dcnt == DONE_LAST) state_n = ST_IDLE;
            else                   dcnt_n  = dcnt + DW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_IDLE;
      presc      <= '0;
      dcnt       <= '0;
      bus.mag_on <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      dcnt       <= dcnt_n;
      bus.mag_on <= (state_n == ST_RUN);
      bus.done   <= (state_n == ST_DONE);
    end
  end

  bcd_down_digit #(.W(SONES_W), .MAX(MAX_SONES)) u_sones (
    .clk(clk), .clear(clear), .load(dig_load),
    .d(dig_zero ? '0 : bus.sones_in), .dec_en(dec),
    .q(sones_q), .borrow(sones_borrow)
  );

  bcd_down_digit #(.W(STENS_W), .MAX(MAX_STENS)) u_stens (
    .clk(clk), .clear(clear), .load(dig_load),
    .d(dig_zero ? '0 : bus.stens_in), .dec_en(sones_borrow),
    .q(stens_q), .borrow(stens_borrow)
  );

  bcd_down_digit #(.W(MIN_W), .MAX(MAX_MIN)) u_min (
    .clk(clk), .clear(clear), .load(dig_load),
    .d(dig_zero ? '0 : bus.min_in), .dec_en(stens_borrow),
    .q(min_q), .borrow(unused_min_borrow)
  );

  assign bus.min_out   = min_q;
  assign bus.stens_out = stens_q;
  assign bus.sones_out = sones_q;
  assign bus.state_out = state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for the microwave cooking timer.
module tb_microwave_timer_ctrl;

  logic clk = 1'b0;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  microwave_timer_ctrl_if bus ();

  microwave_timer_ctrl #(.TICKS_PER_SEC(4), .DONE_SECS(2)) dut (
    .clk(clk), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [3:0] m, input logic [2:0] t,
                          input logic [3:0] o);
    chk(tag, 32'({bus.min_out, bus.stens_out, bus.sones_out}), 32'({m, t, o}));
  endtask

  task automatic do_load(input logic [3:0] m, input logic [2:0] t, input logic [3:0] o);
    bus.load = 1'b1; bus.min_in = m; bus.stens_in = t; bus.sones_in = o;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    bus.load = 1'b0; bus.min_in = '0; bus.stens_in = '0; bus.sones_in = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_closed = 1'b1;
    ticks(2);
    clear = 1'b0;
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk_time("rst_time", 4'd0, 3'd0, 4'd0);
    chk("rst_mag", 32'(bus.mag_on), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // 1: basic countdown 0:03 to DONE and auto return
    do_load(4'd0, 3'd0, 4'd3);
    chk_time("t1_load", 4'd0, 3'd0, 4'd3);
    do_start();
    chk("t1_run_mag", 32'(bus.mag_on), 32'd1);
    chk("t1_run_state", 32'(bus.state_out), 32'd1);
    ticks(3);
    chk_time("t1_pre_dec", 4'd0, 3'd0, 4'd3);
    tick();
    chk_time("t1_dec1", 4'd0, 3'd0, 4'd2);
    ticks(4);
    chk_time("t1_dec2", 4'd0, 3'd0, 4'd1);
    ticks(4);
    chk_time("t1_dec3", 4'd0, 3'd0, 4'd0);
    chk("t1_done_state", 32'(bus.state_out), 32'd3);
    chk("t1_done_mag", 32'(bus.mag_on), 32'd0);
    chk("t1_done_flag", 32'(bus.done), 32'd1);
    ticks(7);
    chk("t1_done_hold", 32'(bus.state_out), 32'd3);
    tick();
    chk("t1_back_idle", 32'(bus.state_out), 32'd0);
    chk("t1_done_clr", 32'(bus.done), 32'd0);

    // 2: borrow chains
    do_load(4'd1, 3'd0, 4'd0);
    do_start();
    ticks(4);
    chk_time("t2_borrow_min", 4'd0, 3'd5, 4'd9);
    do_stop();
    do_stop();
    chk_time("t2_cancel", 4'd0, 3'd0, 4'd0);
    do_load(4'd0, 3'd1, 4'd0);
    do_start();
    ticks(4);
    chk_time("t2_borrow_stens", 4'd0, 3'd0, 4'd9);
    do_stop();
    do_stop();

    // 3: pause holds prescaler; wrap coinciding with pause is dropped
    do_load(4'd0, 3'd0, 4'd5);
    do_start();
    ticks(6);
    do_stop();
    chk("t3_pause_state", 32'(bus.state_out), 32'd2);
    chk("t3_pause_mag", 32'(bus.mag_on), 32'd0);
    ticks(10);
    chk_time("t3_pause_hold", 4'd0, 3'd0, 4'd4);
    do_start();
    chk("t3_resume", 32'(bus.state_out), 32'd1);
    tick();
    chk_time("t3_resume_m1", 4'd0, 3'd0, 4'd4);
    tick();
    chk_time("t3_resume_dec", 4'd0, 3'd0, 4'd3);
    ticks(3);
    do_stop();
    chk_time("t3_wrap_suppr", 4'd0, 3'd0, 4'd3);
    do_start();
    tick();
    chk_time("t3_wrap_resume", 4'd0, 3'd0, 4'd2);
    do_stop();
    do_stop();

    // 4: door interlock
    do_load(4'd0, 3'd0, 4'd5);
    do_start();
    bus.door_closed = 1'b0;
    tick();
    chk("t4_door_pause", 32'(bus.state_out), 32'd2);
    do_start();
    chk("t4_open_start", 32'(bus.state_out), 32'd2);
    bus.door_closed = 1'b1;
    do_start();
    chk("t4_close_start", 32'(bus.mag_on), 32'd1);
    do_stop();
    chk("t4_stop1", 32'(bus.state_out), 32'd2);
    do_stop();
    chk("t4_stop2", 32'(bus.state_out), 32'd0);
    chk_time("t4_cancel_time", 4'd0, 3'd0, 4'd0);

    // 5: IDLE load validation and priority
    do_load(4'd1, 3'd2, 4'd3);
    chk_time("t5_valid", 4'd1, 3'd2, 4'd3);
    do_load(4'd4, 3'd6, 4'd5);
    chk_time("t5_bad_stens", 4'd1, 3'd2, 4'd3);
    do_load(4'd4, 3'd4, 4'd10);
    chk_time("t5_bad_sones", 4'd1, 3'd2, 4'd3);
    bus.start = 1'b1;
    do_load(4'd0, 3'd4, 4'd5);
    bus.start = 1'b0;
    chk_time("t5_load_prio", 4'd0, 3'd4, 4'd5);
    chk("t5_load_idle", 32'(bus.state_out), 32'd0);
    do_stop();
    chk_time("t5_idle_stop", 4'd0, 3'd0, 4'd0);
    do_start();
    chk("t5_zero_start", 32'(bus.state_out), 32'd0);
    chk("t5_zero_mag", 32'(bus.mag_on), 32'd0);

    // 6: clear mid-RUN and in DONE, door open in DONE
    do_load(4'd0, 3'd0, 4'd7);
    do_start();
    ticks(2);
    chk("t6_running", 32'(bus.mag_on), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_state", 32'(bus.state_out), 32'd0);
    chk_time("t6_clr_time", 4'd0, 3'd0, 4'd0);
    chk("t6_clr_mag", 32'(bus.mag_on), 32'd0);
    chk("t6_clr_done", 32'(bus.done), 32'd0);
    do_load(4'd0, 3'd0, 4'd1);
    do_start();
    ticks(4);
    chk("t6_in_done", 32'(bus.state_out), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_done_st", 32'(bus.state_out), 32'd0);
    chk("t6_clr_done_fl", 32'(bus.done), 32'd0);
    do_load(4'd0, 3'd0, 4'd1);
    do_start();
    ticks(4);
    bus.door_closed = 1'b0;
    tick();
    bus.door_closed = 1'b1;
    chk("t6_door_done", 32'(bus.state_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
